// File: rtl/bfc_hash_feeder_if.sv
// Byte-stream handshake and counter-strobe bundle for the Bloom-filter hash feeder.
interface bfc_hash_feeder_if #(
  parameter int unsigned DEPTH = 4
) ();
  localparam int unsigned LevelW = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_data;
  logic              flush;
  logic              out_enable;
  logic [7:0]        out_data;
  logic              out_clear;
  logic [LevelW-1:0] fifo_level;

  // Upstream / test side drives bytes and flush, observes everything else.
  modport master (
    output in_valid,
    output in_data,
    output flush,
    input  in_ready,
    input  out_enable,
    input  out_data,
    input  out_clear,
    input  fifo_level
  );

  // Feeder side.
  modport slave (
    input  in_valid,
    input  in_data,
    input  flush,
    output in_ready,
    output out_enable,
    output out_data,
    output out_clear,
    output fifo_level
  );
endinterface

// File: rtl/bfc_hash_feeder.sv
// Bloom-filter hash feeder: buffers bytes in a small FIFO, hashes each popped byte to a
// 4-bit filter index and issues one strobe per cycle, with a one-cycle clear every WINDOW items.
module bfc_hash_feeder #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned WINDOW = 256,
  parameter logic [7:0]  SEED   = 8'hA5
) (
  input logic              clk,
  input logic              reset,
  bfc_hash_feeder_if.slave bus
);
  localparam int unsigned     PtrW    = $clog2(DEPTH);
  localparam int unsigned     LevelW  = PtrW + 1;
  localparam logic [LevelW-1:0] DepthL  = LevelW'(DEPTH);
  localparam logic [15:0]     WindowL = 16'(WINDOW);

  typedef enum logic [0:0] {StRun, StClear} state_e;

  logic [7:0]        mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LevelW-1:0] level_q, level_d;
  logic [15:0]       win_cnt_q, win_cnt_d;
  state_e            state_q, state_d;
  logic              out_enable_q, out_enable_d;
  logic              out_clear_q, out_clear_d;
  logic [7:0]        out_data_q, out_data_d;
  logic              in_ready;
  logic              push;
  logic              pop;
  logic              win_hit;
  logic [3:0]        pop_idx;

  // Pre-whiten, fold with a 3-bit rotation, then xor the nibbles together.
  function automatic logic [3:0] hash_idx(input logic [7:0] d);
    logic [7:0] x;
    logic [7:0] y;
    x = d ^ SEED;
    y = {x[4:0], x[7:5]} ^ x;
    return y[3:0] ^ y[7:4];
  endfunction

  // Handshake qualifiers; in_ready follows the registered level only (no pop bypass).
  always_comb begin
    in_ready = !bus.flush && (level_q < DepthL);
    push     = bus.in_valid && in_ready;
    pop      = (state_q == StRun) && (level_q != '0) && !bus.flush;
    win_hit  = (win_cnt_q + 16'd1) == WindowL;
    pop_idx  = hash_idx(mem_q[rd_ptr_q]);
  end

  // FIFO storage; contents need no reset because the level gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.in_data;
    end
  end

  // FIFO pointer and occupancy next-state; flush empties the buffer outright.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   level_d = level_q + LevelW'(1);
        2'b01:   level_d = level_q - LevelW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // FIFO pointer and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; a flush during CLEAR returns to RUN so only one clear pulse results.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (bus.flush || (pop && win_hit)) begin
          state_d = StClear;
        end
      end
      StClear: state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  // FSM outputs and window count next state; outputs are registered one cycle later.
  always_comb begin
    out_enable_d = 1'b0;
    out_data_d   = out_data_q;
    out_clear_d  = (state_q == StClear);
    win_cnt_d    = win_cnt_q;
    if (bus.flush || (state_q == StClear)) begin
      win_cnt_d = '0;
    end else if (pop) begin
      win_cnt_d = win_cnt_q + 16'd1;
    end
    if (pop) begin
      out_enable_d = 1'b1;
      out_data_d   = {4'b0000, pop_idx};
    end
  end

  // Registered strobes, data and window count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_enable_q <= 1'b0;
      out_clear_q  <= 1'b0;
      out_data_q   <= '0;
      win_cnt_q    <= '0;
    end else begin
      out_enable_q <= out_enable_d;
      out_clear_q  <= out_clear_d;
      out_data_q   <= out_data_d;
      win_cnt_q    <= win_cnt_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_enable = out_enable_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_clear  = out_clear_q;
  assign bus.fifo_level = level_q;

endmodule

// File: tb/tb_bfc_hash_feeder.sv
// Scoreboard bench: dut_a uses WINDOW=4, dut_b uses WINDOW=1, both DEPTH=4.
module tb_bfc_hash_feeder;
  localparam logic [8:0] ClrEv = 9'h100;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [8:0] qa[$];
  logic [8:0] qb[$];
  int   cnt_a;
  int   cnt_b;
  logic saw_full;

  bfc_hash_feeder_if #(.DEPTH(4)) if_a ();
  bfc_hash_feeder_if #(.DEPTH(4)) if_b ();

  bfc_hash_feeder #(.DEPTH(4), .WINDOW(4), .SEED(8'hA5)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (if_a.slave)
  );

  bfc_hash_feeder #(.DEPTH(4), .WINDOW(1), .SEED(8'hA5)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (if_b.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic [7:0] d, input logic f);
    if (sel == 0) begin
      if_a.in_valid = v; if_a.in_data = d; if_a.flush = f;
    end else begin
      if_b.in_valid = v; if_b.in_data = d; if_b.flush = f;
    end
  endtask

  task automatic get(input int sel, output logic rdy, output logic [2:0] lvl, output logic en,
                     output logic clr, output logic [7:0] dat);
    if (sel == 0) begin
      rdy = if_a.in_ready; lvl = if_a.fifo_level; en = if_a.out_enable;
      clr = if_a.out_clear; dat = if_a.out_data;
    end else begin
      rdy = if_b.in_ready; lvl = if_b.fifo_level; en = if_b.out_enable;
      clr = if_b.out_clear; dat = if_b.out_data;
    end
  endtask

  // Expected output events in order: items, with a clear after every window's last item.
  task automatic record(input int sel, input logic [3:0] idx);
    if (sel == 0) begin
      qa.push_back({5'b0, idx});
      cnt_a++;
      if (cnt_a == 4) begin qa.push_back(ClrEv); cnt_a = 0; end
    end else begin
      qb.push_back({5'b0, idx});
      cnt_b++;
      if (cnt_b == 1) begin qb.push_back(ClrEv); cnt_b = 0; end
    end
  endtask

  task automatic expect_pop(input int sel, input logic [8:0] act, input string name);
    logic [8:0] e;
    if ((sel == 0 && qa.size() == 0) || (sel != 0 && qb.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL %s_unexpected: got %0h expected no output", name, act);
    end else begin
      if (sel == 0) e = qa.pop_front();
      else e = qb.pop_front();
      chk(name, 32'(act), 32'(e));
    end
  endtask

  task automatic mon(input int sel);
    logic rdy, en, clr;
    logic [2:0] lvl;
    logic [7:0] dat;
    get(sel, rdy, lvl, en, clr, dat);
    if (en && clr) chk(sel == 0 ? "a_en_and_clr" : "b_en_and_clr", 32'({en, clr}), 32'h0);
    if (en) expect_pop(sel, {1'b0, dat}, sel == 0 ? "a_item" : "b_item");
    if (clr) expect_pop(sel, ClrEv, sel == 0 ? "a_clear" : "b_clear");
  endtask

  // Monitor: compares each presented output against the scoreboard queues.
  always @(negedge clk) begin
    if (!reset) begin
      mon(0);
      mon(1);
    end
  end

  task automatic push(input int sel, input logic [7:0] b, input logic [3:0] idx);
    logic rdy, en, clr;
    logic [2:0] lvl;
    logic [7:0] dat;
    int guard;
    @(negedge clk);
    drive(sel, 1'b1, b, 1'b0);
    #1;
    get(sel, rdy, lvl, en, clr, dat);
    chk("in_ready_vs_level", 32'(rdy), 32'(lvl < 3'd4));
    if (lvl == 3'd4) saw_full = 1'b1;
    guard = 0;
    while (!rdy && guard < 40) begin
      @(negedge clk);
      #1;
      get(sel, rdy, lvl, en, clr, dat);
      chk("in_ready_vs_level", 32'(rdy), 32'(lvl < 3'd4));
      if (lvl == 3'd4) saw_full = 1'b1;
      guard++;
    end
    if (!rdy) begin
      chk("push_wait_timeout", 32'(rdy), 32'h1);
      drive(sel, 1'b0, 8'h00, 1'b0);
    end else begin
      @(posedge clk);
      record(sel, idx);
      #1;
      drive(sel, 1'b0, 8'h00, 1'b0);
    end
  endtask

  task automatic wait_drain(input int sel, input string name);
    int n;
    n = 0;
    while (((sel == 0) ? qa.size() : qb.size()) != 0 && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    repeat (4) @(negedge clk);
    chk(name, (sel == 0) ? qa.size() : qb.size(), 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    qa.delete(); qb.delete();
    cnt_a = 0; cnt_b = 0;
    @(negedge clk);
    @(negedge clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic chk_idle(input int sel, input string name);
    logic rdy, en, clr;
    logic [2:0] lvl;
    logic [7:0] dat;
    get(sel, rdy, lvl, en, clr, dat);
    chk({name, "_in_ready"}, 32'(rdy), 32'h1);
    chk({name, "_out_enable"}, 32'(en), 32'h0);
    chk({name, "_out_clear"}, 32'(clr), 32'h0);
    chk({name, "_fifo_level"}, 32'(lvl), 32'h0);
    chk({name, "_out_data"}, 32'(dat), 32'h0);
  endtask

  initial begin
    logic [7:0] b3 [6];
    logic [3:0] i3 [6];
    logic [7:0] b4 [8];
    logic [3:0] i4 [8];
    b3 = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
    i3 = '{4'h9, 4'h3, 4'hA, 4'h6, 4'hF, 4'h5};
    b4 = '{8'h00, 8'h01, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
    i4 = '{4'h0, 4'h9, 4'h9, 4'h3, 4'hA, 4'h6, 4'hF, 4'h5};
    clk = 1'b0; reset = 1'b1; checks = 0; errors = 0; cnt_a = 0; cnt_b = 0; saw_full = 1'b0;
    drive(0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0);

    // Reset values after release.
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk_idle(0, "rst_a");
    chk_idle(1, "rst_b");

    // Single byte latency: handshake in N, strobe in N+2 only.
    push(0, 8'h00, 4'h0);
    @(negedge clk); #1;
    chk("lat_n1_enable", 32'(if_a.out_enable), 32'h0);
    @(negedge clk); #1;
    chk("lat_n2_enable", 32'(if_a.out_enable), 32'h1);
    chk("lat_n2_data", 32'(if_a.out_data), 32'h00);
    @(negedge clk); #1;
    chk("lat_n3_enable", 32'(if_a.out_enable), 32'h0);
    push(0, 8'h01, 4'h9);
    wait_drain(0, "drain_single");

    // Window of 4: six bytes give 4 items, a clear, then 2 items.
    pulse_reset();
    for (int i = 0; i < 6; i++) push(0, b3[i], i3[i]);
    wait_drain(0, "drain_window4");

    // Flush exactly while the window clear is pending: one clear pulse only.
    push(0, 8'h00, 4'h0);
    push(0, 8'h01, 4'h9);
    @(negedge clk);
    @(negedge clk);
    drive(0, 1'b0, 8'h00, 1'b1);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 8'h00, 1'b0);
    qa.delete(); qa.push_back(ClrEv); cnt_a = 0;
    @(negedge clk); #1;
    chk("flush_in_clear_pulse", 32'(if_a.out_clear), 32'h1);
    @(negedge clk); #1;
    chk("flush_in_clear_no_second", 32'(if_a.out_clear), 32'h0);
    wait_drain(0, "drain_flush_clear");

    // Reset mid-window with 2 bytes queued.
    for (int i = 0; i < 6; i++) push(0, b3[i], i3[i]);
    push(0, 8'h00, 4'h0);
    @(negedge clk);
    #1;
    chk("pre_reset_level", 32'(if_a.fifo_level), 32'h2);
    #1;
    reset = 1'b1;
    qa.delete(); qb.delete(); cnt_a = 0; cnt_b = 0;
    #1;
    chk_idle(0, "midrst");
    @(negedge clk);
    @(negedge clk);
    #2;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) push(0, b3[i], i3[i]);
    wait_drain(0, "drain_after_reset");

    // Window of 1: burst of 8 fills the FIFO and every item is followed by a clear.
    for (int i = 0; i < 8; i++) push(1, b4[i], i4[i]);
    wait_drain(1, "drain_burst");
    chk("burst_reached_full", 32'(saw_full), 32'h1);

    // Flush with 3 bytes queued and a byte offered in the same cycle.
    for (int i = 0; i < 5; i++) push(1, b3[i], i3[i]);
    @(negedge clk);
    chk("flush_level_before", 32'(if_b.fifo_level), 32'h3);
    drive(1, 1'b1, 8'h77, 1'b1);
    #1;
    chk("flush_in_ready", 32'(if_b.in_ready), 32'h0);
    @(posedge clk);
    #1;
    drive(1, 1'b0, 8'h00, 1'b0);
    qb.delete(); qb.push_back(ClrEv); cnt_b = 0;
    @(negedge clk); #1;
    chk("flush_level_after", 32'(if_b.fifo_level), 32'h0);
    chk("flush_no_enable", 32'(if_b.out_enable), 32'h0);
    wait_drain(1, "drain_flush");
    chk("flush_level_final", 32'(if_b.fifo_level), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
